// File: rtl/timer_bus_pkg.sv
// Shared types and constants for the timer register-bus master.
// Build option TIMER_BUS_MASTER_RMW_EN enables the read-modify-write operation.
package timer_bus_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RMW   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_RD = 2'd1,
    ACC_WR = 2'd2,
    RSP    = 2'd3
  } state_e;

  // Timer register map (word aligned)
  localparam logic [ADDR_W-1:0] REG_CTRL     = 6'h00;
  localparam logic [ADDR_W-1:0] REG_STATUS   = 6'h04;
  localparam logic [ADDR_W-1:0] REG_LOAD     = 6'h08;
  localparam logic [ADDR_W-1:0] REG_COUNT    = 6'h0C;
  localparam logic [ADDR_W-1:0] REG_CMP0     = 6'h10;
  localparam logic [ADDR_W-1:0] REG_CMP1     = 6'h14;
  localparam logic [ADDR_W-1:0] REG_IRQ_EN   = 6'h18;
  localparam logic [ADDR_W-1:0] REG_IRQ_STAT = 6'h1C;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mask;
  } cmd_t;

  function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] old_val,
                                                  input logic [DATA_W-1:0] new_val,
                                                  input logic [DATA_W-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/timer_bus_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module timer_bus_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // A full FIFO refuses the push even when the head is popped in the same cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/timer_bus_master.sv
// Queues timer register commands and runs them one at a time on a single-cycle cs bus.
// Build option TIMER_BUS_MASTER_RMW_EN enables op 2 (read-modify-write).
module timer_bus_master
  import timer_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output state_e            state_dbg
);

  // Handshakes: a command transfers on a clk edge with cmd_valid && cmd_ready, a response
  // on a clk edge with rsp_valid && rsp_ready; a valid side holds its payload until then.

  cmd_t                    push_cmd;
  cmd_t                    head;
  logic [$bits(cmd_t)-1:0] head_bits;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;
  logic                    head_bad;
  logic                    head_rd;
  state_e                  state;
  state_e                  state_nxt;
  logic                    rmw_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;

  always_comb begin
    push_cmd.op    = op_e'(cmd_op);
    push_cmd.addr  = cmd_addr;
    push_cmd.wdata = cmd_wdata;
`ifdef TIMER_BUS_MASTER_RMW_EN
    push_cmd.mask  = cmd_mask;
`else
    push_cmd.mask  = '0;
`endif
  end

`ifndef TIMER_BUS_MASTER_RMW_EN
  logic unused_mask;
  assign unused_mask = ^{cmd_mask, head.mask};
`endif

  timer_bus_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (head_bits),
    .empty     (fifo_empty)
  );

  assign head      = cmd_t'(head_bits);
  assign cmd_ready = !fifo_full;

  // Classify the FIFO head: misaligned or unsupported ops never touch the bus
  always_comb begin
    head_rd  = 1'b0;
    head_bad = 1'b0;
    case (head.op)
      OP_READ:  head_rd = 1'b1;
      OP_WRITE: head_rd = 1'b0;
`ifdef TIMER_BUS_MASTER_RMW_EN
      OP_RMW:   head_rd = 1'b1;
`endif
      default:  head_bad = 1'b1;
    endcase
    if (head.addr[1:0] != 2'b00) head_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_bad)     state_nxt = RSP;
          else if (head_rd) state_nxt = ACC_RD;
          else              state_nxt = ACC_WR;
        end
      end
      ACC_RD:  state_nxt = rmw_q ? ACC_WR : RSP;
      ACC_WR:  state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop       = (state == IDLE) && !fifo_empty;
    cs        = (state == ACC_RD) || (state == ACC_WR);
    rsp_valid = (state == RSP);
    busy      = !fifo_empty || (state != IDLE);
    state_dbg = state;
  end

`ifdef TIMER_BUS_MASTER_RMW_EN
  logic [DATA_W-1:0] mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            mask_q <= '0;
    else if (state == IDLE && !fifo_empty) mask_q <= head.mask;
  end
`endif

  // Bus and response registers; an RMW reuses wdata_q to carry the new value into the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmw_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            rmw_q   <= (head.op == OP_RMW) && !head_bad;
            we_q    <= !head_bad && !head_rd;
            addr_q  <= head.addr;
            wdata_q <= head.wdata;
            rdata_q <= '0;
            err_q   <= head_bad;
          end
        end
        ACC_RD: begin
          rdata_q <= rdata;
`ifdef TIMER_BUS_MASTER_RMW_EN
          if (rmw_q) begin
            we_q    <= 1'b1;
            wdata_q <= rmw_merge(rdata, wdata_q, mask_q);
          end
`endif
        end
        ACC_WR:  we_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign we        = we_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_timer_bus_master.sv
// Directed bench for timer_bus_master with a register-file target and in-order scoreboards.
module tb_timer_bus_master;
  import timer_bus_pkg::*;

  // bus entry: {b2b_ok, we, addr[5:0], wdata[31:0], cyc[31:0]}; rsp entry: {err, rdata[31:0], cyc[31:0]}
  localparam int BW = 72;
  localparam int RW = 65;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, cs, we, busy;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr, addr;
  logic [31:0] cmd_wdata, cmd_mask, rsp_rdata, wdata, rdata;
  state_e      state_dbg;

  logic [31:0] tgt_mem [16];
  logic [31:0] shd [16];
  logic [BW-1:0] bus_q [$];
  logic [RW-1:0] exp_q [$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic cs_prev = 1'b0;
  logic rsp_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_bus_master #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cs(cs), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
    .state_dbg(state_dbg)
  );

  // Register-file target: combinational read in the cs cycle, write at the closing edge
  assign rdata = cs ? tgt_mem[addr[5:2]] : 32'h0;
  always @(posedge clk) if (cs && we) tgt_mem[addr[5:2]] <= wdata;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] at_cyc(input bit en, input int v);
    return en ? v : 32'h0;
  endfunction

  // Monitor: pops the expected queues whenever the DUT presents a bus cycle or a response
  always @(negedge clk) begin : mon
    logic [BW-1:0] be;
    logic [RW-1:0] re;
    if (cs) begin
      if (bus_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL bus_unexpected: got cs at addr 0x%02h, expected no bus cycle", addr);
      end else begin
        be = bus_q.pop_front();
        check("bus_we", we, be[70]);
        check("bus_addr", addr, be[69:64]);
        if (be[70]) check("bus_wdata", wdata, be[63:32]);
        if (be[31:0] != 0) check("bus_cycle", cyc, be[31:0]);
        if (cs_prev && !be[71]) begin
          n_chk++; n_fail++;
          $display("FAIL bus_back_to_back: got cs in consecutive cycles, expected a gap");
        end
      end
    end
    cs_prev = cs;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid err=%0b rdata=0x%08h, expected none", rsp_err, rsp_rdata);
      end else begin
        re = exp_q[0];
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          if (re[31:0] != 0) check("rsp_cycle", cyc, re[31:0]);
        end
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          check("rsp_err", rsp_err, re[64]);
          check("rsp_rdata", rsp_rdata, re[63:32]);
          rsp_seen = 1'b0;
        end
      end
    end
  end

  // Driver: called at posedge+1, returns at posedge+1 after the accepting edge E0
  task automatic send(input logic [1:0] op, input logic [5:0] a, input logic [31:0] wd,
                      input logic [31:0] m, input bit chk_lat);
    int n, c, idx;
    bit bad, rmw;
    logic [31:0] old_v, new_v;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 200);
    if (!cmd_ready) begin
      n_chk++; n_fail++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0 for %0d cycles, expected acceptance", n);
      cmd_valid = 1'b0;
      return;
    end
    c = cyc;
    idx = a[5:2];
    old_v = shd[idx];
    rmw = 1'b0;
`ifdef TIMER_BUS_MASTER_RMW_EN
    rmw = (op == 2'd2);
`endif
    bad = (a[1:0] != 2'b00) || (op == 2'd3) || (op == 2'd2 && !rmw);
    if (bad) begin
      exp_q.push_back({1'b1, 32'h0, at_cyc(chk_lat, c + 2)});
    end else if (op == 2'd0) begin
      bus_q.push_back({1'b0, 1'b0, a, 32'h0, at_cyc(chk_lat, c + 2)});
      exp_q.push_back({1'b0, old_v, at_cyc(chk_lat, c + 3)});
    end else if (op == 2'd1) begin
      bus_q.push_back({1'b0, 1'b1, a, wd, at_cyc(chk_lat, c + 2)});
      exp_q.push_back({1'b0, 32'h0, at_cyc(chk_lat, c + 3)});
      shd[idx] = wd;
    end else begin
      new_v = (old_v & ~m) | (wd & m);
      bus_q.push_back({1'b0, 1'b0, a, 32'h0, at_cyc(chk_lat, c + 2)});
      bus_q.push_back({1'b1, 1'b1, a, new_v, at_cyc(chk_lat, c + 3)});
      exp_q.push_back({1'b0, old_v, at_cyc(chk_lat, c + 4)});
      shd[idx] = new_v;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0 || busy) && n < max) begin
      @(negedge clk); n++;
    end
    check("drain_done", n < max, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] saved;
    for (int i = 0; i < 16; i++) begin
      tgt_mem[i] = 32'h1111_1111 * i;
      shd[i]     = 32'h1111_1111 * i;
    end
    tgt_mem[0] = 32'h0000_00F0; shd[0] = 32'h0000_00F0;
    tgt_mem[2] = 32'hDEAD_BEEF; shd[2] = 32'hDEAD_BEEF;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("reset_cs", cs, 0);
    check("reset_we", we, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_busy", busy, 0);
    check("reset_addr", addr, 0);
    check("reset_wdata", wdata, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_state", state_dbg, IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    @(posedge clk); #1;

    send(2'd1, 6'h04, 32'h0000_1234, 32'h0, 1'b1);
    drain(50);
    check("target_write", tgt_mem[1], 32'h0000_1234);
    send(2'd0, 6'h08, 32'h0, 32'h0, 1'b1);
    drain(50);
    send(2'd2, 6'h00, 32'h0000_0005, 32'h0000_000F, 1'b1);
    drain(50);
`ifdef TIMER_BUS_MASTER_RMW_EN
    check("target_rmw", tgt_mem[0], 32'h0000_00F5);
`else
    check("target_rmw_untouched", tgt_mem[0], 32'h0000_00F0);
`endif
    send(2'd0, 6'h06, 32'h0, 32'h0, 1'b1);
    drain(50);
    send(2'd3, 6'h0C, 32'h0, 32'h0, 1'b1);
    drain(50);
    send(2'd0, 6'h04, 32'h0, 32'h0, 1'b1);
    drain(50);

    // Backpressure: one command parked in RSP plus four queued fills the FIFO
    rsp_ready = 1'b0;
    send(2'd0, 6'h10, 32'h0, 32'h0, 1'b1);
    send(2'd1, 6'h14, 32'hA5A5_0001, 32'h0, 1'b0);
    send(2'd0, 6'h14, 32'h0, 32'h0, 1'b0);
    send(2'd0, 6'h01, 32'h0, 32'h0, 1'b0);
    send(2'd0, 6'h1C, 32'h0, 32'h0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 6'h18; cmd_wdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_ready_low", cmd_ready, 0);
    end
    check("full_busy", busy, 1);
    check("full_rsp_held", rsp_valid, 1);
    check("full_rsp_rdata_held", rsp_rdata, shd[4]);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain(200);

    // Reset in the middle of an access with another command queued behind it
    saved = shd[6];
`ifdef TIMER_BUS_MASTER_RMW_EN
    send(2'd2, 6'h18, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0);
    send(2'd0, 6'h1C, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
`else
    send(2'd1, 6'h18, 32'hFFFF_0000, 32'h0, 1'b0);
    send(2'd0, 6'h1C, 32'h0, 32'h0, 1'b0);
`endif
    check("pre_reset_cs", cs, 1);
    check("pre_reset_we", we, 1);
    rst_n = 1'b0;
    #1;
    bus_q.delete(); exp_q.delete();
    rsp_seen = 1'b0; cs_prev = 1'b0;
    check("abort_cs", cs, 0);
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_state", state_dbg, IDLE);
    shd[6] = saved;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_ready", cmd_ready, 1);
    check("aborted_write_absent", tgt_mem[6], saved);
    send(2'd0, 6'h18, 32'h0, 32'h0, 1'b1);
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/timer_bus_master.md
TIMER_BUS_MASTER -- requirements
Module: timer_bus_master

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, the command FIFO depth (power of two, >=2).
REQ-002 The block SHALL have port clk, input, 1, clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1, command request.
REQ-005 The block SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-006 The block SHALL have port cmd_op, input, 2, operation: 0 READ, 1 WRITE, 2 RMW, 3 reserved.
REQ-007 The block SHALL have ports cmd_addr (input, 6), cmd_wdata (input, 32) and cmd_mask (input, 32, RMW bit-select).
REQ-008 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 32) and rsp_err (output, 1).
REQ-009 The block SHALL have generic register-bus ports cs, we (output, 1 each), addr (output, 6), wdata (output, 32) and rdata (input, 32, combinational from the target in the cs cycle).
REQ-010 The block SHALL have port busy, output, 1, high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-011 cmd_ready SHALL equal !fifo_full; a push is blocked when full even if a pop occurs in the same cycle.
REQ-012 The FSM SHALL have states IDLE, ACC_RD, ACC_WR, RSP; IDLE pops the FIFO head when non-empty.
REQ-013 From IDLE, a READ or RMW SHALL go to ACC_RD, a WRITE to ACC_WR, and a reserved op or cmd_addr[1:0]!=0 directly to RSP with rsp_err=1 and no bus cycle.
REQ-014 Each bus access SHALL assert cs for exactly one cycle, with we/addr/wdata registered and stable in that cycle; we=0 in ACC_RD and 1 in ACC_WR.
REQ-015 rdata SHALL be sampled at the clock edge ending the ACC_RD cycle.
REQ-016 An RMW SHALL go ACC_RD -> ACC_WR back to back and write (old & ~mask) | (cmd_wdata & mask).
REQ-017 Latency: with the command accepted at edge E0 into an empty FIFO, the first cs cycle SHALL be E1-E2; rsp_valid SHALL rise after E2 (READ/WRITE), E3 (RMW), or E1 (error).
REQ-018 rsp_rdata SHALL be the read data for READ, the pre-modify value for RMW, and 0 for WRITE or error.
REQ-019 In RSP, rsp_valid/rsp_rdata/rsp_err SHALL hold until rsp_ready; on handshake the FSM returns to IDLE.
REQ-020 Only one command SHALL be outstanding; responses SHALL be in command order, exactly one per command.
REQ-021 cs SHALL never be asserted in two consecutive cycles except within an RMW.

Reset
REQ-022 On rst_n low, cs, we, rsp_valid, rsp_err and busy SHALL be 0, addr/wdata/rsp_rdata SHALL be 0, the FIFO SHALL be empty, and the FSM SHALL be IDLE; cmd_ready SHALL be 1 after deassertion.
REQ-023 Reset mid-access or mid-RMW SHALL abort immediately with no further bus cycle and no response for aborted or queued commands.

Configuration
REQ-024 Macro TIMER_BUS_MASTER_RMW_EN: when defined, op 2 SHALL perform RMW per REQ-016.
REQ-025 When TIMER_BUS_MASTER_RMW_EN is undefined, op 2 SHALL be treated as reserved (error, no bus cycle), and cmd_mask SHALL be unused.

Structure
REQ-026 Package timer_bus_pkg SHALL hold the op enum (OP_READ, OP_WRITE, OP_RMW, OP_RSVD), the FSM state enum, the address width (6), the data width (32) and the timer register offset constants (0x00-0x1C).
REQ-027 The command FIFO SHALL be a sub-module timer_bus_cmd_fifo (sync, registered, full/empty flags, pointer wrap).

Verification
REQ-028 WRITE addr 0x04 wdata 0x0000_1234 -> one cs cycle with we=1, addr=0x04, wdata=0x1234; response rdata=0, err=0.
REQ-029 READ addr 0x08 with target rdata 0xDEAD_BEEF -> cs with we=0; rsp_rdata=0xDEADBEEF after E2.
REQ-030 RMW addr 0x00, old 0x0000_00F0, mask 0x0F, wdata 0x05 (macro on) -> read then write 0x0000_00F5 in consecutive cycles; rsp_rdata=0xF0. With the macro off -> rsp_err=1, no cs.
REQ-031 Push 5 commands with rsp_ready=0 -> cmd_ready drops after the 4 queued plus 1 in flight; releasing rsp_ready drains all, in order.
REQ-032 Addr 0x06 or op 3 -> rsp_err=1 after E1, cs never asserted.
REQ-033 rst_n pulsed during the RMW write cycle -> cs low immediately, busy=0, no response, FIFO empty.
